uart_tx_arbiter: RTL and testbench

- Packet-level round-robin arbiter sharing the single UART byte transmitter among NUM_REQ requesters.
- Sits between the requesters and the transmitter, which is paced by the baud-rate generator's tx_en ticks.
- Accepts one byte at a time per requester, issues a one-cycle start to the transmitter, then waits for the transmitter's busy window to close.
- A requester keeps ownership until its last byte is sent, or until it stalls for LOCK_TIMEOUT cycles.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_rr_pick.sv | 21 ++
 rtl/uart_tx_arbiter.sv | 104 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: bit timing used by the baud generator and the
// arbiter state encoding.
package uart_pkg;
  localparam int CLKS_PER_BIT = 434;
  localparam int OVERSAMPLE   = 16;

  typedef enum logic [2:0] {IDLE, START, BUSY_WAIT, DONE_WAIT, HOLD} arb_state_t;
endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first requester after last_owner, wrapping,
// with last_owner itself at lowest priority.
module uart_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_owner,
  output logic [IDW-1:0]     winner,
  output logic               any_req
);
  always_comb begin
    winner  = last_owner;
    any_req = |req;
    // Walk from farthest to nearest so the closest requester overwrites last.
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(last_owner) + k) % NUM_REQ])
        winner = IDW'((int'(last_owner) + k) % NUM_REQ);
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter in front of the shared UART byte transmitter.
// The owner keeps the transmitter until its last byte or a mid-packet stall timeout.
import uart_pkg::*;

module uart_tx_arbiter #(
  parameter  int NUM_REQ      = 4,
  parameter  int DATA_W       = 8,
  parameter  int LOCK_TIMEOUT = 4340,
  localparam int IDW          = $clog2(NUM_REQ),
  localparam int CW           = $clog2(LOCK_TIMEOUT + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [IDW-1:0]            active_id,
  output logic                      arb_busy
);
  arb_state_t     state, state_nx;
  logic [IDW-1:0] last_owner, pick, latch_id;
  logic           any_req, lock, lock_nx, latch;
  logic [CW-1:0]  hold_cnt, hold_cnt_nx;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (req),
    .last_owner (last_owner),
    .winner     (pick),
    .any_req    (any_req)
  );

  always_comb begin
    state_nx    = state;
    lock_nx     = lock;
    hold_cnt_nx = hold_cnt;
    latch       = 1'b0;
    latch_id    = active_id;
    case (state)
      IDLE: if (any_req) begin
        latch    = 1'b1;
        latch_id = pick;
        state_nx = START;
      end
      START:     state_nx = BUSY_WAIT;
      BUSY_WAIT: if (tx_busy) state_nx = DONE_WAIT;
      DONE_WAIT: if (!tx_busy) begin
        if (!lock) state_nx = IDLE;
        else if (req[active_id]) begin
          latch    = 1'b1;
          state_nx = START;
        end else begin
          state_nx    = HOLD;
          hold_cnt_nx = '0;
        end
      end
      HOLD: begin
        // A request arriving on the expiry cycle keeps the lock.
        if (req[active_id]) begin
          latch    = 1'b1;
          state_nx = START;
        end else if (hold_cnt == CW'(LOCK_TIMEOUT - 1)) begin
          lock_nx  = 1'b0;
          state_nx = IDLE;
        end else begin
          hold_cnt_nx = hold_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (latch) lock_nx = ~req_last[latch_id];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lock       <= 1'b0;
      hold_cnt   <= '0;
      last_owner <= IDW'(NUM_REQ - 1);
      active_id  <= '0;
      tx_data    <= '0;
      gnt        <= '0;
      tx_start   <= 1'b0;
      arb_busy   <= 1'b0;
    end else begin
      state    <= state_nx;
      lock     <= lock_nx;
      hold_cnt <= hold_cnt_nx;
      arb_busy <= (state_nx != IDLE);
      gnt      <= '0;
      tx_start <= 1'b0;
      if (latch) begin
        active_id <= latch_id;
        tx_data   <= req_data[latch_id*DATA_W +: DATA_W];
        gnt       <= NUM_REQ'(1) << latch_id;
        tx_start  <= 1'b1;
        if (state == IDLE) last_owner <= latch_id;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: packet-level round-robin model plus
// directed lock-timeout, expiry-race and mid-frame reset scenarios.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int LT  = 24;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*W-1:0]  req_data = '0;
  logic [N-1:0]    req_last = '0;
  logic [N-1:0]    gnt;
  logic            tx_start;
  logic [W-1:0]    tx_data;
  logic            tx_busy;
  logic [IDW-1:0]  active_id;
  logic            arb_busy;

  int checks = 0;
  int failures = 0;

  typedef struct {int id; logic [7:0] data;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [8:0] rq[N][$];
  logic [8:0] mq[N][$];
  int mdl_last = N - 1;
  bit auto_on = 1'b0;
  int busy_cnt = 0;
  logic prev_start = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_last(req_last),
    .gnt(gnt), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .active_id(active_id), .arb_busy(arb_busy)
  );

  // Transmitter model: busy for 10 cycles starting the edge after tx_start.
  assign tx_busy = (busy_cnt != 0);
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every start pops the next expected byte.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_start) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_start actual_id=%0d data=%0h required=none", active_id, tx_data);
        end else begin
          mon_e = sb.pop_front();
          chk("active_id", 32'(active_id), 32'(mon_e.id));
          chk("tx_data", 32'(tx_data), 32'(mon_e.data));
          chk("gnt_onehot", 32'(gnt), 32'(1) << mon_e.id);
        end
        chk("start_single_cycle", 32'(prev_start), 32'(0));
      end else begin
        chk("gnt_without_start", 32'(gnt), 32'(0));
      end
      prev_start = tx_start;
    end else begin
      prev_start = 1'b0;
    end
  end

  // Requester driver: presents the head of each queue until granted.
  initial forever begin
    @(posedge clk); #1;
    if (auto_on) begin
      for (int i = 0; i < N; i++) begin
        if (gnt[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          req[i] = 1'b1;
          req_data[i*W +: W] = rq[i][0][7:0];
          req_last[i] = rq[i][0][8];
        end else begin
          req[i] = 1'b0;
        end
      end
    end
  end

  task automatic add_pkt(input int i, input int len);
    for (int b = 0; b < len; b++)
      rq[i].push_back({(b == len - 1), 8'($urandom_range(0, 255))});
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    bit pend;
    do begin
      @(negedge clk);
      n++;
      pend = (sb.size() != 0) || arb_busy;
      for (int i = 0; i < N; i++) if (rq[i].size() != 0) pend = 1'b1;
    end while (pend && n < budget);
    if (pend) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=pending required=idle_within_%0d", nm, budget);
    end
  endtask

  task automatic wait_gnt(input int i, input int budget, input string nm, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[i] && n < budget);
    if (!gnt[i]) begin
      checks++; failures++;
      $display("FAIL %s_no_gnt actual=%0b required_bit=%0d", nm, gnt, i);
    end
  endtask

  task automatic wait_busy(input logic lvl, input string nm);
    int n = 0;
    while (tx_busy !== lvl && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (tx_busy !== lvl) begin
      checks++; failures++;
      $display("FAIL %s_busy actual=%0b required=%0b", nm, tx_busy, lvl);
    end
  endtask

  // Packet-level model: all queued packets are presented together, so grants
  // follow round-robin over requesters with whole packets kept together.
  task automatic model_and_go(input string nm);
    int found;
    logic [8:0] b;
    for (int i = 0; i < N; i++) mq[i] = rq[i];
    while (1) begin
      found = -1;
      for (int k = 1; k <= N; k++) begin
        automatic int c = (mdl_last + k) % N;
        if (found < 0 && mq[c].size() > 0) found = c;
      end
      if (found < 0) break;
      mdl_last = found;
      do begin
        b = mq[found].pop_front();
        sb.push_back('{found, b[7:0]});
      end while (!b[8]);
    end
    auto_on = 1'b1;
    wait_idle(6000, nm);
    auto_on = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic manual_req(input int i, input logic [7:0] d, input logic last);
    req[i] = 1'b1;
    req_data[i*W +: W] = d;
    req_last[i] = last;
  endtask

  int n, gap;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_active_id", 32'(active_id), 0);
    chk("rst_arb_busy", 32'(arb_busy), 0);

    // Single byte from requester 0: one-cycle latency, release timing.
    @(posedge clk); #1;
    manual_req(0, 8'h55, 1'b1);
    sb.push_back('{0, 8'h55});
    mdl_last = 0;
    @(negedge clk);
    chk("latency_same_cycle", 32'(tx_start), 0);
    @(negedge clk);
    chk("latency_next_cycle", 32'(tx_start), 1);
    chk("latency_tx_data", 32'(tx_data), 32'h55);
    @(posedge clk); #1 req[0] = 1'b0;
    wait_busy(1'b1, "t1_rise");
    wait_busy(1'b0, "t1_fall");
    chk("arb_busy_1_after_fall", 32'(arb_busy), 1);
    @(negedge clk);
    chk("arb_busy_2_after_fall", 32'(arb_busy), 0);
    wait_idle(100, "t1");

    // All four requesting single-byte packets, two rounds.
    for (int i = 0; i < N; i++) begin add_pkt(i, 1); add_pkt(i, 1); end
    model_and_go("rr_all");

    // Requester 2 three-byte packet against constant requester 0.
    add_pkt(2, 3);
    for (int k = 0; k < 4; k++) add_pkt(0, 1);
    model_and_go("locked_pkt");

    // Randomized packet mixes.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++)
        for (int p = $urandom_range(0, 2); p > 0; p--) add_pkt(i, $urandom_range(1, 3));
      model_and_go("random");
    end

    // Lock timeout: requester 1 stalls mid-packet, requester 3 waits.
    manual_req(1, 8'hA1, 1'b0);
    sb.push_back('{1, 8'hA1});
    mdl_last = 1;
    wait_gnt(1, 10, "to_first", n);
    @(posedge clk); #1;
    req[1] = 1'b0;
    manual_req(3, 8'h3C, 1'b1);
    sb.push_back('{3, 8'h3C});
    wait_busy(1'b1, "to_rise");
    wait_busy(1'b0, "to_fall");
    wait_gnt(3, LT + 20, "to_release", gap);
    chk("timeout_gap", 32'(gap + 1), 32'(LT + 3));
    mdl_last = 3;
    @(posedge clk); #1 req[3] = 1'b0;
    wait_idle(200, "timeout");

    // Expiry race: owner re-requests on the final HOLD cycle and keeps the lock.
    manual_req(1, 8'hB2, 1'b0);
    sb.push_back('{1, 8'hB2});
    wait_gnt(1, 10, "race_first", n);
    @(posedge clk); #1;
    req[1] = 1'b0;
    manual_req(3, 8'h4D, 1'b1);
    wait_busy(1'b1, "race_rise");
    wait_busy(1'b0, "race_fall");
    repeat (LT) @(negedge clk);
    manual_req(1, 8'hC3, 1'b1);
    sb.push_back('{1, 8'hC3});
    sb.push_back('{3, 8'h4D});
    wait_gnt(1, 2, "race_win", n);
    @(posedge clk); #1 req[1] = 1'b0;
    wait_gnt(3, 100, "race_after", n);
    mdl_last = 3;
    @(posedge clk); #1 req[3] = 1'b0;
    wait_idle(200, "race");

    // Reset during DONE_WAIT.
    manual_req(0, 8'h5A, 1'b0);
    sb.push_back('{0, 8'h5A});
    wait_gnt(0, 10, "rst_first", n);
    @(posedge clk); #1 req[0] = 1'b0;
    wait_busy(1'b1, "rst_rise");
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt), 0);
    chk("midrst_tx_start", 32'(tx_start), 0);
    chk("midrst_tx_data", 32'(tx_data), 0);
    chk("midrst_active_id", 32'(active_id), 0);
    chk("midrst_arb_busy", 32'(arb_busy), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    mdl_last = N - 1;
    @(posedge clk); #1;
    manual_req(2, 8'h77, 1'b1);
    sb.push_back('{2, 8'h77});
    wait_gnt(2, 10, "post_rst", n);
    @(posedge clk); #1 req[2] = 1'b0;
    wait_idle(200, "post_rst");

    chk("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
